// File: rtl/button_press_conditioner.sv
// Raw push-button conditioner: 2-flop sync, debounce, press/release pulses and hold auto-repeat.
// Latency 2 + DEBOUNCE_LIMIT cycles from a settled i_Switch change to o_Switch; no backpressure, pulses are fire-and-forget.
module button_press_conditioner #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int HOLD_DELAY     = 12500000,
  parameter int REPEAT_PERIOD  = 5000000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press_Pulse,
  output logic o_Release_Pulse,
  output logic o_Held
);

  localparam int DB_W     = $clog2(DEBOUNCE_LIMIT);
  localparam int HOLD_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int HC_W     = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [HC_W-1:0] HOLD_LAST   = HC_W'(HOLD_DELAY - 1);
  localparam logic [HC_W-1:0] REPEAT_LAST = HC_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  logic            r_Sync1;
  logic            r_Sync2;
  logic            w_Sync;
  logic [DB_W-1:0] r_Db_Cnt;
  logic            w_Db_Toggle;
  logic            w_Rise;
  logic            w_Fall;
  logic [HC_W-1:0] r_Hold_Cnt;
  state_t          r_State;

  assign w_Sync = r_Sync2;

  // The cycle the debounce run completes is the cycle o_Switch flips, so the
  // FSM keys off this strobe to land its pulses alongside the new level.
  assign w_Db_Toggle = (w_Sync != o_Switch) && (r_Db_Cnt == DB_LAST);
  assign w_Rise      = w_Db_Toggle && !o_Switch;
  assign w_Fall      = w_Db_Toggle &&  o_Switch;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Sync1  <= 1'b0;
      r_Sync2  <= 1'b0;
      r_Db_Cnt <= '0;
      o_Switch <= 1'b0;
    end else begin
      r_Sync1 <= i_Switch;
      r_Sync2 <= r_Sync1;
      if (w_Sync == o_Switch) begin
        r_Db_Cnt <= '0;
      end else if (w_Db_Toggle) begin
        r_Db_Cnt <= '0;
        o_Switch <= ~o_Switch;
      end else begin
        r_Db_Cnt <= r_Db_Cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State         <= IDLE;
      r_Hold_Cnt      <= '0;
      o_Press_Pulse   <= 1'b0;
      o_Release_Pulse <= 1'b0;
      o_Held          <= 1'b0;
    end else begin
      o_Press_Pulse   <= 1'b0;
      o_Release_Pulse <= 1'b0;
      case (r_State)
        IDLE: begin
          if (w_Rise) begin
            o_Press_Pulse <= 1'b1;
            r_Hold_Cnt    <= '0;
            r_State       <= PRESSED;
          end
        end
        PRESSED: begin
          if (w_Fall) begin
            o_Release_Pulse <= 1'b1;
            o_Held          <= 1'b0;
            r_State         <= IDLE;
          end else if (r_Hold_Cnt == HOLD_LAST) begin
            o_Press_Pulse <= 1'b1;
            o_Held        <= 1'b1;
            r_Hold_Cnt    <= '0;
            r_State       <= REPEAT;
          end else begin
            r_Hold_Cnt <= r_Hold_Cnt + HC_W'(1);
          end
        end
        REPEAT: begin
          // Release is checked first so it suppresses a coincident repeat.
          if (w_Fall) begin
            o_Release_Pulse <= 1'b1;
            o_Held          <= 1'b0;
            r_State         <= IDLE;
          end else if (r_Hold_Cnt == REPEAT_LAST) begin
            o_Press_Pulse <= 1'b1;
            r_Hold_Cnt    <= '0;
          end else begin
            r_Hold_Cnt <= r_Hold_Cnt + HC_W'(1);
          end
        end
        default: begin
          o_Held  <= 1'b0;
          r_State <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_conditioner.sv
// Bench for button_press_conditioner: directed scenarios plus random press/bounce traffic,
// every cycle compared against a window/arithmetic model of the debounce and pulse schedule.
module tb_button_press_conditioner;

  localparam int DL = 4;
  localparam int HD = 20;
  localparam int RP = 8;

  logic i_Clk = 1'b0;
  logic i_Rst_L;
  logic i_Switch;
  logic o_Switch;
  logic o_Press_Pulse;
  logic o_Release_Pulse;
  logic o_Held;

  button_press_conditioner #(
    .DEBOUNCE_LIMIT(DL),
    .HOLD_DELAY    (HD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rst_L        (i_Rst_L),
    .i_Switch       (i_Switch),
    .o_Switch       (o_Switch),
    .o_Press_Pulse  (o_Press_Pulse),
    .o_Release_Pulse(o_Release_Pulse),
    .o_Held         (o_Held)
  );

  always #5 i_Clk = ~i_Clk;

  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;

  // Reference model: raw samples newest-first, debounced level, cycle of last rise.
  logic raw_q[$];
  logic m_sw;
  int   m_T;
  logic e_press, e_rel, e_held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    raw_q = {};
    for (int j = 0; j < DL + 2; j++) raw_q.push_back(1'b0);
    m_sw    = 1'b0;
    m_T     = 0;
    e_press = 1'b0;
    e_rel   = 1'b0;
    e_held  = 1'b0;
  endtask

  task automatic check_outputs();
    chk("switch",  o_Switch,        m_sw);
    chk("press",   o_Press_Pulse,   e_press);
    chk("release", o_Release_Pulse, e_rel);
    chk("held",    o_Held,          e_held);
    chk("excl",    o_Press_Pulse & o_Release_Pulse, 0);
  endtask

  // One clock: drive the raw switch, advance the model at the edge, compare 1 time unit later.
  task automatic tick(input logic sw);
    logic all1, all0, prev;
    int   d;
    i_Switch = sw;
    @(posedge i_Clk);
    cyc++;
    if (!i_Rst_L) begin
      model_reset();
    end else begin
      raw_q.push_front(sw);
      void'(raw_q.pop_back());
      // New level accepted once the last DL synchronised samples (raw delayed by 2) all agree.
      all1 = 1'b1;
      all0 = 1'b1;
      for (int j = 2; j <= DL + 1; j++) begin
        if (raw_q[j] !== 1'b1) all1 = 1'b0;
        if (raw_q[j] !== 1'b0) all0 = 1'b0;
      end
      prev = m_sw;
      if (all1) m_sw = 1'b1;
      else if (all0) m_sw = 1'b0;
      if (!prev && m_sw) m_T = cyc;
      d       = cyc - m_T;
      e_rel   = prev && !m_sw;
      e_held  = m_sw && (d >= HD);
      e_press = m_sw && ((d == 0) || (d == HD) || (d > HD && ((d - HD) % RP) == 0));
    end
    #1;
    check_outputs();
  endtask

  initial begin
    int lat, cnt_p, cnt_r, cnt_s, first_p, t0;
    int rel_q[$];
    int exp_rep[4];
    logic bounce[9];
    exp_rep = '{20, 28, 36, 44};
    bounce  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state
    i_Switch = 1'b0;
    i_Rst_L  = 1'b1;
    model_reset();
    #2 i_Rst_L = 1'b0;
    #1;
    check_outputs();
    repeat (3) tick(1'b0);
    @(negedge i_Clk) i_Rst_L = 1'b1;
    repeat (5) tick(1'b0);

    // First press: latency 6 edges, single-cycle pulse, not held
    lat = -1;
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      tick(1'b1);
      if (o_Press_Pulse === 1'b1) lat = i;
    end
    chk("press_latency", lat, 6);
    chk("held_at_press", o_Held, 0);
    t0 = cyc;

    // Hold 50 cycles: repeats at +20,+28,+36,+44
    rel_q = {};
    for (int k = 1; k <= 50; k++) begin
      tick(1'b1);
      if (o_Press_Pulse === 1'b1) rel_q.push_back(cyc - t0);
      if (k == 1)  chk("pulse_one_cycle", o_Press_Pulse, 0);
      if (k == 19) chk("held_before_hd", o_Held, 0);
      if (k == 20) chk("held_at_hd", o_Held, 1);
    end
    chk("repeat_count", rel_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("repeat_time", (rel_q.size() > i) ? rel_q[i] : -1, exp_rep[i]);
    repeat (12) tick(1'b0);

    // Glitch shorter than the debounce window
    cnt_p = 0; cnt_r = 0; cnt_s = 0;
    for (int k = 0; k < 13; k++) begin
      tick(k < 3 ? 1'b1 : 1'b0);
      cnt_p += int'(o_Press_Pulse === 1'b1);
      cnt_r += int'(o_Release_Pulse === 1'b1);
      cnt_s += int'(o_Switch === 1'b1);
    end
    chk("glitch_press", cnt_p, 0);
    chk("glitch_release", cnt_r, 0);
    chk("glitch_switch", cnt_s, 0);

    // Bounce then steady high: one press, 5 ticks after the final run starts at index 5
    cnt_p = 0; first_p = -1;
    for (int k = 0; k < 30; k++) begin
      tick(k < 9 ? bounce[k] : 1'b1);
      if (o_Press_Pulse === 1'b1) begin
        cnt_p++;
        if (first_p < 0) first_p = k;
      end
    end
    chk("bounce_press_count", cnt_p, 1);
    chk("bounce_press_time", first_p, 10);
    repeat (12) tick(1'b0);

    // Release landing on a scheduled repeat slot at T+36
    lat = -1;
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      tick(1'b1);
      if (o_Press_Pulse === 1'b1) lat = i;
    end
    chk("press_latency2", lat, 6);
    for (int k = 1; k <= 36; k++) begin
      tick(k <= 30 ? 1'b1 : 1'b0);
      if (k == 35) chk("held_before_rel", o_Held, 1);
      if (k == 36) begin
        chk("rel_pulse", o_Release_Pulse, 1);
        chk("rel_no_press", o_Press_Pulse, 0);
        chk("rel_held", o_Held, 0);
      end
    end
    repeat (4) tick(1'b0);

    // Asynchronous reset in the middle of REPEAT
    lat = -1;
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      tick(1'b1);
      if (o_Press_Pulse === 1'b1) lat = i;
    end
    chk("press_latency3", lat, 6);
    repeat (25) tick(1'b1);
    chk("held_pre_reset", o_Held, 1);
    #2 i_Rst_L = 1'b0;
    model_reset();
    #1;
    chk("rst_switch",  o_Switch, 0);
    chk("rst_press",   o_Press_Pulse, 0);
    chk("rst_release", o_Release_Pulse, 0);
    chk("rst_held",    o_Held, 0);
    repeat (2) tick(1'b1);
    @(negedge i_Clk) i_Rst_L = 1'b1;
    lat = -1;
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      tick(1'b1);
      if (o_Press_Pulse === 1'b1) lat = i;
    end
    chk("post_reset_latency", lat, 6);
    for (int k = 1; k <= 20; k++) begin
      tick(1'b1);
      if (k == 19) chk("post_reset_held_early", o_Held, 0);
      if (k == 20) chk("post_reset_held", o_Held, 1);
    end
    repeat (12) tick(1'b0);

    // Random traffic: short bounces mixed with long holds
    for (int s = 0; s < 40; s++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 45));
      repeat (len) tick(lvl);
    end
    repeat (12) tick(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
